// File: rtl/alu_ctrl_issue_if.sv
// ----------------------------------------------------------------------------
// alu_ctrl_issue_if
// Bundles the decode-side and ALU-side handshakes of the EX-stage ALU issue
// buffer.
//   Decode side : in_valid, in_ready, alu_op[1:0], funct[5:0], in_a, in_b
//   Control     : flush (drop all buffered ops, branch redirect)
//   ALU side    : out_valid, out_ready, out_control[2:0], out_a, out_b,
//                 out_illegal
//   Status      : illegal_cnt[7:0]
// modport master : the producer of ops / consumer of ALU issue (decode + EX)
// modport slave  : the issue buffer itself
// ----------------------------------------------------------------------------
interface alu_ctrl_issue_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_control;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_illegal;
    logic [7:0]        illegal_cnt;

    modport master (
        output in_valid, alu_op, funct, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_control, out_a, out_b, out_illegal,
               illegal_cnt
    );

    modport slave (
        input  in_valid, alu_op, funct, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_control, out_a, out_b, out_illegal,
               illegal_cnt
    );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ----------------------------------------------------------------------------
// alu_ctrl_issue
// Producer end of the EX-stage ALU interface. Decodes ALUOp + funct into the
// 3-bit ALU control code and issues {control, A, B} through a 2-entry skid
// buffer so decode can keep streaming while EX stalls.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_ctrl_issue_if.slave (decode handshake, flush, ALU handshake,
//            illegal_cnt)
// Parameters:
//   DATA_W : operand width
//   DEPTH  : skid entries, only 2 is supported
// Build option:
//   ALU_CTRL_ILLEGAL_CNT_EN : when defined, illegal_cnt counts accepted
//   undecodable ops (saturating at 8'hFF); otherwise illegal_cnt is 8'h00.
// ----------------------------------------------------------------------------
module alu_ctrl_issue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input logic             clk,
    input logic             rst_n,
    alu_ctrl_issue_if.slave bus
);
    localparam logic [2:0] CTRL_ADD = 3'b010;

    typedef struct packed {
        logic              ill;
        logic [2:0]        ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    // Returns {illegal, control}. Undecodable ops fall back to add.
    function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] r;
        r = {1'b1, CTRL_ADD};
        case (op)
            2'b00: r = {1'b0, 3'b010};
            2'b01: r = {1'b0, 3'b110};
            2'b10: begin
                case (f)
                    6'b100000: r = {1'b0, 3'b010};
                    6'b100010: r = {1'b0, 3'b110};
                    6'b100100: r = {1'b0, 3'b000};
                    6'b100101: r = {1'b0, 3'b001};
                    6'b101010: r = {1'b0, 3'b111};
                    default:   r = {1'b1, CTRL_ADD};
                endcase
            end
            default: r = {1'b1, CTRL_ADD};
        endcase
        return r;
    endfunction

    entry_t     mem_q [DEPTH];
    entry_t     mem_d [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic       live_q;

    logic       accept;
    logic       pop;
    logic [3:0] dec;
    entry_t     new_entry;

    // ---- decode / handshake (combinational, input side) ----
    always_comb begin
        dec           = decode(bus.alu_op, bus.funct);
        new_entry.ill = dec[3];
        new_entry.ctrl = dec[2:0];
        new_entry.a   = bus.in_a;
        new_entry.b   = bus.in_b;

        bus.in_ready  = live_q && (count_q < 2'(DEPTH));
        bus.out_valid = (count_q != 2'd0);
        accept        = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            // A same-cycle pop has already been taken by the ALU; a
            // same-cycle accept is dropped along with the buffered ops.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, accept} - {1'b0, pop};
        end
    end

    // ---- buffer state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{ill: 1'b0, ctrl: CTRL_ADD, a: '0, b: '0};
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            live_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

    // ---- output side: oldest entry, straight from registers ----
    always_comb begin
        bus.out_control = mem_q[rd_ptr_q].ctrl;
        bus.out_a       = mem_q[rd_ptr_q].a;
        bus.out_b       = mem_q[rd_ptr_q].b;
        bus.out_illegal = mem_q[rd_ptr_q].ill;
    end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [7:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && !bus.flush && new_entry.ill && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    // Only rst_n clears the counter; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= 8'h00;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.illegal_cnt = illegal_cnt_q;
`else
    assign bus.illegal_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_ctrl_issue_if #(.DATA_W(32)) bus ();

    alu_ctrl_issue #(.DATA_W(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of issued ops plus a table of legal R-type functs.
    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } ent_t;

    ent_t        mq[$];
    bit          m_live;
    int          m_cnt;
    logic [5:0]  legal_f [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0]  legal_c [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    function automatic ent_t ref_op(input logic [1:0] op, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
        ent_t e;
        e.a = a; e.b = b; e.c = 3'b010; e.ill = 1'b1;
        if (op == 2'd0) begin e.c = 3'b010; e.ill = 1'b0; end
        else if (op == 2'd1) begin e.c = 3'b110; e.ill = 1'b0; end
        else if (op == 2'd2) begin
            for (int i = 0; i < 5; i++)
                if (legal_f[i] == f) begin e.c = legal_c[i]; e.ill = 1'b0; end
        end
        return e;
    endfunction

    function automatic logic [7:0] exp_cnt();
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        return 8'(m_cnt);
`else
        return 8'h00;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("in_ready", 32'(bus.in_ready), 32'(m_live && mq.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("out_control", 32'(bus.out_control), 32'(mq[0].c));
            check("out_a", bus.out_a, mq[0].a);
            check("out_b", bus.out_b, mq[0].b);
            check("out_illegal", 32'(bus.out_illegal), 32'(mq[0].ill));
        end
        check("illegal_cnt", 32'(bus.illegal_cnt), 32'(exp_cnt()));
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input logic ordy);
        bus.in_valid = v; bus.alu_op = op; bus.funct = f;
        bus.in_a = a; bus.in_b = b; bus.flush = fl; bus.out_ready = ordy;
    endtask

    // One clock: predict transfers from pre-edge inputs, update model, check at negedge.
    task automatic cycle();
        bit   acc, pop;
        ent_t e;
        acc = bus.in_valid && m_live && (mq.size() < 2);
        pop = (mq.size() > 0) && bus.out_ready;
        e   = ref_op(bus.alu_op, bus.funct, bus.in_a, bus.in_b);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (bus.flush) mq.delete();
        else if (acc) begin
            mq.push_back(e);
            if (e.ill && m_cnt < 255) m_cnt++;
        end
        m_live = 1'b1;
        @(negedge clk);
        check_model();
    endtask

    initial begin
        tests = 0; fails = 0; m_live = 1'b0; m_cnt = 0;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_control", 32'(bus.out_control), 32'b010);
        check("rst out_a", bus.out_a, 32'd0);
        check("rst out_b", bus.out_b, 32'd0);
        check("rst out_illegal", 32'(bus.out_illegal), 32'd0);
        check("rst illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

        // Stream: and / or / slt with out_ready high, one-cycle lag
        drive(1'b1, 2'd2, 6'b100100, 32'h11, 32'h21, 1'b0, 1'b1); cycle();
        check("stream and", 32'(bus.out_control), 32'b000);
        drive(1'b1, 2'd2, 6'b100101, 32'h12, 32'h22, 1'b0, 1'b1); cycle();
        check("stream or", 32'(bus.out_control), 32'b001);
        drive(1'b1, 2'd2, 6'b101010, 32'h13, 32'h23, 1'b0, 1'b1); cycle();
        check("stream slt", 32'(bus.out_control), 32'b111);
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1); cycle();
        check("stream drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: three pushes with out_ready low
        drive(1'b1, 2'd0, 6'd0, 32'hA1, 32'hB1, 1'b0, 1'b0); cycle();
        drive(1'b1, 2'd1, 6'd0, 32'hA2, 32'hB2, 1'b0, 1'b0); cycle();
        check("bp full in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 2'd2, 6'b100000, 32'hA3, 32'hB3, 1'b0, 1'b0); cycle();
        check("bp hold op1", bus.out_a, 32'hA1);
        drive(1'b1, 2'd2, 6'b100000, 32'hA3, 32'hB3, 1'b0, 1'b1); cycle();
        check("bp op2 next", bus.out_a, 32'hA2);
        // count=1: op3 enters while op2 leaves
        drive(1'b1, 2'd2, 6'b100000, 32'hA3, 32'hB3, 1'b0, 1'b1); cycle();
        check("push+pop op3", bus.out_a, 32'hA3);
        check("push+pop no bubble", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1); cycle();

        // Illegal ops
        drive(1'b1, 2'd3, 6'd0, 32'hC1, 32'hD1, 1'b0, 1'b1); cycle();
        check("illegal op11 ctrl", 32'(bus.out_control), 32'b010);
        check("illegal op11 flag", 32'(bus.out_illegal), 32'd1);
        drive(1'b1, 2'd2, 6'b000000, 32'hC2, 32'hD2, 1'b0, 1'b1); cycle();
        check("illegal funct flag", 32'(bus.out_illegal), 32'd1);
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1); cycle();
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        check("illegal_cnt two", 32'(bus.illegal_cnt), 32'd2);
`else
        check("illegal_cnt tied", 32'(bus.illegal_cnt), 32'd0);
`endif

        // Flush at count=2 with a push pending
        drive(1'b1, 2'd0, 6'd0, 32'hE1, 32'hF1, 1'b0, 1'b0); cycle();
        drive(1'b1, 2'd0, 6'd0, 32'hE2, 32'hF2, 1'b0, 1'b0); cycle();
        drive(1'b1, 2'd0, 6'd0, 32'hE3, 32'hF3, 1'b1, 1'b0); cycle();
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1); cycle();
        check("flush push absent", 32'(bus.out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
            drive(1'($urandom), op, f, $urandom, $urandom,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
            cycle();
        end

        // Asynchronous reset mid-stream
        drive(1'b1, 2'd0, 6'd0, 32'h55, 32'h66, 1'b0, 1'b0); cycle();
        drive(1'b1, 2'd0, 6'd0, 32'h57, 32'h68, 1'b0, 1'b0); cycle();
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst in_ready", 32'(bus.in_ready), 32'd0);
        check("async rst illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
        mq.delete(); m_live = 1'b0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 6'd0, 32'h77, 32'h88, 1'b0, 1'b0); cycle();
        check("post-rst not yet", 32'(bus.out_valid), 32'd0);
        cycle();
        check("post-rst first op", bus.out_a, 32'h77);
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1); cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
